// File: rtl/bus_initiator.sv
// Single-beat bus initiator: takes one request, runs an ADDR/DATA bus transaction and returns one response.
// Optional data-phase timeout abort is enabled by defining BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  input  logic        req_rnw_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  input  logic        rsp_ready_i,
  output logic [31:0] bus_addrData_o,
  output logic [3:0]  bus_byteEnables_o,
  output logic [7:0]  bus_burstSize_o,
  output logic        bus_readNWrite_o,
  output logic        bus_beginTransaction_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  input  logic [31:0] bus_addrData_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  input  logic        bus_busy_i,
  input  logic        bus_error_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_rnw;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_initiator: TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timeout_cnt;
`endif

  // Only single-beat transfers are issued.
  assign bus_burstSize_o = 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      req_ready_o            <= 1'b1;
      rsp_valid_o            <= 1'b0;
      rsp_rdata_o            <= 32'd0;
      rsp_err_o              <= 1'b0;
      lat_addr               <= 32'd0;
      lat_wdata              <= 32'd0;
      lat_be                 <= 4'd0;
      lat_rnw                <= 1'b0;
      bus_addrData_o         <= 32'd0;
      bus_byteEnables_o      <= 4'd0;
      bus_readNWrite_o       <= 1'b0;
      bus_beginTransaction_o <= 1'b0;
      bus_endTransaction_o   <= 1'b0;
      bus_dataValid_o        <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      timeout_cnt            <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            state                  <= ADDR;
            req_ready_o            <= 1'b0;
            lat_addr               <= req_addr_i;
            lat_wdata              <= req_wdata_i;
            lat_be                 <= req_be_i;
            lat_rnw                <= req_rnw_i;
            bus_beginTransaction_o <= 1'b1;
            bus_addrData_o         <= req_addr_i;
            bus_byteEnables_o      <= req_be_i;
            bus_readNWrite_o       <= req_rnw_i;
          end
        end

        // Address phase is held from the latched copy until the slave drops busy.
        ADDR: begin
          if (bus_busy_i) begin
            bus_addrData_o    <= lat_addr;
            bus_byteEnables_o <= lat_be;
          end else begin
            state                  <= DATA;
            bus_beginTransaction_o <= 1'b0;
            bus_addrData_o         <= lat_rnw ? 32'd0 : lat_wdata;
            bus_dataValid_o        <= ~lat_rnw;
            bus_endTransaction_o   <= ~lat_rnw;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            timeout_cnt            <= 16'd0;
`endif
          end
        end

        DATA: begin
          if (bus_endTransaction_i) begin
            state                <= RESP;
            rsp_valid_o          <= 1'b1;
            rsp_rdata_o          <= (lat_rnw && bus_dataValid_i) ? bus_addrData_i : 32'd0;
            rsp_err_o            <= bus_error_i;
            bus_addrData_o       <= 32'd0;
            bus_byteEnables_o    <= 4'd0;
            bus_readNWrite_o     <= 1'b0;
            bus_endTransaction_o <= 1'b0;
            bus_dataValid_o      <= 1'b0;
          end else begin
`ifdef BUS_INITIATOR_TIMEOUT_EN
            timeout_cnt <= timeout_cnt + 16'd1;
            if (timeout_cnt == TIMEOUT_LAST) begin
              state                <= RESP;
              rsp_valid_o          <= 1'b1;
              rsp_rdata_o          <= 32'd0;
              rsp_err_o            <= 1'b1;
              bus_addrData_o       <= 32'd0;
              bus_byteEnables_o    <= 4'd0;
              bus_readNWrite_o     <= 1'b0;
              bus_endTransaction_o <= 1'b0;
              bus_dataValid_o      <= 1'b0;
            end
`else
            state <= DATA;
`endif
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: stimulus pushes expected responses, a monitor pops them on each handshake.
// Covers the BUS_INITIATOR_TIMEOUT_EN build as well when that macro is defined.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        req_rnw_i = 1'b0;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] bus_addrData_o;
  logic [3:0]  bus_byteEnables_o;
  logic [7:0]  bus_burstSize_o;
  logic        bus_readNWrite_o;
  logic        bus_beginTransaction_o;
  logic        bus_endTransaction_o;
  logic        bus_dataValid_o;
  logic [31:0] bus_addrData_i = '0;
  logic        bus_endTransaction_i = 1'b0;
  logic        bus_dataValid_i = 1'b0;
  logic        bus_busy_i = 1'b0;
  logic        bus_error_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] sb[$];

  bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_be_i(req_be_i), .req_rnw_i(req_rnw_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_ready_i(rsp_ready_i),
    .bus_addrData_o(bus_addrData_o), .bus_byteEnables_o(bus_byteEnables_o),
    .bus_burstSize_o(bus_burstSize_o), .bus_readNWrite_o(bus_readNWrite_o),
    .bus_beginTransaction_o(bus_beginTransaction_o), .bus_endTransaction_o(bus_endTransaction_o),
    .bus_dataValid_o(bus_dataValid_o),
    .bus_addrData_i(bus_addrData_i), .bus_endTransaction_i(bus_endTransaction_i),
    .bus_dataValid_i(bus_dataValid_i), .bus_busy_i(bus_busy_i), .bus_error_i(bus_error_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every handshake must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        checkOutput("rsp_rdata", rsp_rdata_o, e[32:1]);
        checkOutput("rsp_err", {31'd0, rsp_err_o}, {31'd0, e[0]});
      end
    end
  end

  task automatic checkBusIdle(input string tag);
    checkOutput({tag, "_addrData"}, bus_addrData_o, 32'd0);
    checkOutput({tag, "_flags"}, {28'd0, bus_beginTransaction_o, bus_endTransaction_o,
                                  bus_dataValid_o, bus_readNWrite_o}, 32'd0);
    checkOutput({tag, "_be_burst"}, {20'd0, bus_byteEnables_o, bus_burstSize_o}, 32'd0);
  endtask

  // One full transaction; called #1 after a clock edge with the DUT in IDLE.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic rnw, input int busy_cycles,
                               input logic [31:0] slave_data, input logic slave_dv,
                               input logic slave_err, input int bp_cycles,
                               input logic [31:0] exp_rdata, input logic exp_err);
    checkOutput("idle_ready", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_addr_i = addr; req_wdata_i = wdata; req_be_i = be; req_rnw_i = rnw;
    sb.push_back({exp_rdata, exp_err});
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i <= busy_cycles; i++) begin
      checkOutput("addr_begin", {31'd0, bus_beginTransaction_o}, 32'd1);
      checkOutput("addr_addrData", bus_addrData_o, addr);
      checkOutput("addr_ctl", {19'd0, bus_byteEnables_o, bus_burstSize_o, bus_readNWrite_o},
                  {19'd0, be, 8'd0, rnw});
      checkOutput("addr_req_ready", {31'd0, req_ready_o}, 32'd0);
      bus_busy_i = (i < busy_cycles);
      tick();
    end
    checkOutput("data_begin", {31'd0, bus_beginTransaction_o}, 32'd0);
    checkOutput("data_addrData", bus_addrData_o, rnw ? 32'd0 : wdata);
    checkOutput("data_dv_end", {30'd0, bus_dataValid_o, bus_endTransaction_o},
                rnw ? 32'd0 : 32'd3);
    bus_endTransaction_i = 1'b1; bus_dataValid_i = slave_dv;
    bus_addrData_i = slave_data; bus_error_i = slave_err;
    tick();
    bus_endTransaction_i = 1'b0; bus_dataValid_i = 1'b0; bus_addrData_i = '0; bus_error_i = 1'b0;
    checkOutput("resp_valid", {31'd0, rsp_valid_o}, 32'd1);
    checkBusIdle("resp_bus");
    if (bp_cycles > 0) begin
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
    end
    for (int i = 0; i < bp_cycles; i++) begin
      tick();
      checkOutput("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
      checkOutput("bp_rdata", rsp_rdata_o, exp_rdata);
      checkOutput("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    tick();
    checkOutput("idle_valid", {31'd0, rsp_valid_o}, 32'd0);
    checkOutput("idle_hold_rdata", rsp_rdata_o, exp_rdata);
    checkOutput("idle_hold_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkBusIdle("rst_bus");
    checkOutput("rst_rsp", {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    $display("[TB] starting bus_initiator bench");
    #12;
    checkOutput("reset_ready_valid", {30'd0, req_ready_o, rsp_valid_o}, 32'd2);
    checkOutput("reset_rsp_data", {rsp_rdata_o[30:0], rsp_err_o}, 32'd0);
    checkBusIdle("reset_bus");
    rst_n = 1'b1;
    tick();

    // addr, wdata, be, rnw, busy, slave data, slave dv, slave err, backpressure, exp rdata, exp err
    applyStimulus(32'h00F00004, 32'h000001B2, 4'hF, 1'b0, 0, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0);
    applyStimulus(32'h00F00008, 32'h0,        4'hF, 1'b1, 0, 32'h00000080, 1'b1, 1'b0, 0, 32'h00000080, 1'b0);
    applyStimulus(32'h00F0000C, 32'hA5A5C3C3, 4'h3, 1'b0, 3, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0);
    applyStimulus(32'h12345678, 32'h0,        4'hC, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1'b0, 5, 32'hDEADBEEF, 1'b0);
    applyStimulus(32'h00000040, 32'h0,        4'hF, 1'b1, 1, 32'h55AA55AA, 1'b0, 1'b0, 0, 32'h0,        1'b0);
    applyStimulus(32'h00000044, 32'h0BADF00D, 4'hF, 1'b0, 0, 32'h0,        1'b0, 1'b1, 0, 32'h0,        1'b1);
    applyStimulus(32'h00000048, 32'h0,        4'h1, 1'b1, 0, 32'h00001234, 1'b1, 1'b1, 2, 32'h00001234, 1'b1);
    applyStimulus(32'h0000004C, 32'h11112222, 4'hF, 1'b0, 0, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 32'h0,        1'b0);

    // Reset during DATA aborts without a response; the next request must run normally.
    req_valid_i = 1'b1; req_addr_i = 32'h100; req_wdata_i = 32'h55; req_be_i = 4'h3; req_rnw_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    tick();
    checkOutput("abort_data_dv", {31'd0, bus_dataValid_o}, 32'd1);
    pulseReset();
    applyStimulus(32'h00000200, 32'h0, 4'hF, 1'b1, 0, 32'hCAFE0001, 1'b1, 1'b0, 0, 32'hCAFE0001, 1'b0);

    // Slave never ends the data phase.
    req_valid_i = 1'b1; req_addr_i = 32'h300; req_wdata_i = 32'h77; req_be_i = 4'hF; req_rnw_i = 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
    sb.push_back({32'h0, 1'b1});
    tick();
    req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_data_dv", {31'd0, bus_dataValid_o}, 32'd1);
      checkOutput("to_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      tick();
    end
    checkOutput("to_resp", {31'd0, rsp_valid_o}, 32'd1);
    checkOutput("to_rdata", rsp_rdata_o, 32'd0);
    checkOutput("to_err", {31'd0, rsp_err_o}, 32'd1);
    tick();
    checkOutput("to_idle", {31'd0, req_ready_o}, 32'd1);
`else
    tick();
    req_valid_i = 1'b0;
    tick();
    repeat (1000) tick();
    checkOutput("hang_data_dv", {31'd0, bus_dataValid_o}, 32'd1);
    checkOutput("hang_no_rsp", {30'd0, rsp_valid_o, req_ready_o}, 32'd0);
    pulseReset();
`endif
    applyStimulus(32'h00000400, 32'h9ABCDEF0, 4'hF, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0);

    tick();
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
